// File: rtl/dds_pkg.sv
// Shared DDS constants and control-FSM encoding, reused by the waveform ROMs and the
// tuning-word control logic.
package dds_pkg;

   localparam int DDS_ACC_W   = 32;
   localparam int DDS_PHASE_W = 14;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } dds_state_e;

endpackage

// File: rtl/dds_ftw_buffer.sv
// Tuning-word handshake, pending register and apply-timing FSM. Delivers the active
// frequency tuning word to the accumulator datapath.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | en low; accumulator frozen, handshakes still accepted
// RUN     | accumulating, no word waiting
// PEND    | accumulating, accepted word waits for the next wrap (ready low)
import dds_pkg::*;

module dds_ftw_buffer #(
   parameter int ACC_W = DDS_ACC_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sync_clr,
   input  logic             apply_on_wrap,
   input  logic             ovf,
   input  logic [ACC_W-1:0] ftw_in,
   input  logic             ftw_valid,
   output logic             ftw_ready,
   output logic [ACC_W-1:0] ftw_active
);

   dds_state_e       state_q, state_d;
   logic [ACC_W-1:0] active_q, active_d;
   logic [ACC_W-1:0] pend_q, pend_d;
   logic             pend_vld_q, pend_vld_d;
   logic             ready_q;
   logic             hs;

   assign hs = ftw_valid & ready_q;

   always_comb begin
      active_d   = active_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      if (hs) begin
         // A fresh word supersedes anything held in the pending register.
         if (!apply_on_wrap || sync_clr) begin
            active_d   = ftw_in;
            pend_vld_d = 1'b0;
         end else begin
            pend_d     = ftw_in;
            pend_vld_d = 1'b1;
         end
      end else if (pend_vld_q && (!apply_on_wrap || sync_clr || ovf)) begin
         active_d   = pend_q;
         pend_vld_d = 1'b0;
      end

      state_d = ST_IDLE;
      if (en) begin
         state_d = pend_vld_d ? ST_PEND : ST_RUN;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         active_q   <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         ready_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         active_q   <= active_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         ready_q    <= (state_d != ST_PEND);
      end
   end

   assign ftw_ready  = ready_q;
   assign ftw_active = active_q;

endmodule

// File: rtl/dds_phase_accumulator.sv
// DDS phase accumulator: modulo-2^ACC_W accumulator with registered, offset-adjusted
// ROM phase and a wrap pulse aligned to the first post-overflow phase sample.
import dds_pkg::*;

module dds_phase_accumulator #(
   parameter int ACC_W   = DDS_ACC_W,
   parameter int PHASE_W = DDS_PHASE_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               sync_clr,
   input  logic               apply_on_wrap,
   input  logic [ACC_W-1:0]   ftw_in,
   input  logic               ftw_valid,
   output logic               ftw_ready,
   input  logic [PHASE_W-1:0] poff_in,
   output logic [PHASE_W-1:0] phase,
   output logic               phase_valid,
   output logic               wrap
);

   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [ACC_W:0]     sum;
   logic [ACC_W-1:0]   ftw_active;
   logic               ovf;
   logic               ovf_q;
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic               phase_valid_q;
   logic               wrap_q;

   dds_ftw_buffer #(
      .ACC_W (ACC_W)
   ) u_ftw_buffer (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .sync_clr      (sync_clr),
      .apply_on_wrap (apply_on_wrap),
      .ovf           (ovf),
      .ftw_in        (ftw_in),
      .ftw_valid     (ftw_valid),
      .ftw_ready     (ftw_ready),
      .ftw_active    (ftw_active)
   );

   always_comb begin
      sum   = {1'b0, acc_q} + {1'b0, ftw_active};
      ovf   = en & ~sync_clr & sum[ACC_W];
      acc_d = acc_q;
      if (sync_clr) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = sum[ACC_W-1:0];
      end
      phase_d = acc_q[ACC_W-1 -: PHASE_W] + poff_in;
   end

   // Phase and wrap advance only while enabled so that a paused output holds the
   // last sample and resumes with its successor; the carry is kept across the pause.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q         <= '0;
         ovf_q         <= 1'b0;
         phase_q       <= '0;
         phase_valid_q <= 1'b0;
         wrap_q        <= 1'b0;
      end else begin
         acc_q         <= acc_d;
         phase_valid_q <= en;
         if (sync_clr) begin
            ovf_q <= 1'b0;
         end else if (en) begin
            ovf_q <= ovf;
         end
         if (en) begin
            phase_q <= phase_d;
            wrap_q  <= ovf_q;
         end else begin
            wrap_q  <= 1'b0;
         end
      end
   end

   assign phase       = phase_q;
   assign phase_valid = phase_valid_q;
   assign wrap        = wrap_q;

endmodule

// File: tb/tb_dds_phase_accumulator.sv
// Directed bench for dds_phase_accumulator with hand-computed phase sequences.
module tb_dds_phase_accumulator;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        sync_clr = 1'b0;
   logic        apply_on_wrap = 1'b0;
   logic [31:0] ftw_in = '0;
   logic        ftw_valid = 1'b0;
   logic        ftw_ready;
   logic [13:0] poff_in = '0;
   logic [13:0] phase;
   logic        phase_valid;
   logic        wrap;

   int n_chk = 0;
   int n_bad = 0;

   dds_phase_accumulator #(
      .ACC_W   (32),
      .PHASE_W (14)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .sync_clr      (sync_clr),
      .apply_on_wrap (apply_on_wrap),
      .ftw_in        (ftw_in),
      .ftw_valid     (ftw_valid),
      .ftw_ready     (ftw_ready),
      .poff_in       (poff_in),
      .phase         (phase),
      .phase_valid   (phase_valid),
      .wrap          (wrap)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      en = 1'b0; sync_clr = 1'b0; apply_on_wrap = 1'b0;
      ftw_valid = 1'b0; ftw_in = '0; poff_in = '0;
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
   endtask

   // Loads a word while idle (immediate apply) and then enables accumulation.
   task automatic load_run(input logic [31:0] w);
      apply_on_wrap = 1'b0;
      ftw_in = w;
      ftw_valid = 1'b1;
      step();
      ftw_valid = 1'b0;
      en = 1'b1;
   endtask

   initial begin
      step();
      chk("rst_phase", 32'(phase), 0);
      chk("rst_valid", 32'(phase_valid), 0);
      chk("rst_wrap", 32'(wrap), 0);
      chk("rst_ready", 32'(ftw_ready), 1);

      // Step of one phase LSB: full cycle through the ROM, two wraps 16384 apart.
      do_reset();
      load_run(32'h0004_0000);
      for (int i = 0; i <= 32768; i++) begin
         step();
         chk("ramp_phase", 32'(phase), 32'(i % 16384));
         chk("ramp_wrap", 32'(wrap), 32'((i != 0) && (i % 16384 == 0)));
      end

      // Half-scale step, then with a quarter-turn offset.
      do_reset();
      load_run(32'h8000_0000);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("half_phase", 32'(phase), (i % 2 == 0) ? 0 : 8192);
         chk("half_wrap", 32'(wrap), 32'((i % 2 == 0) && (i != 0)));
      end
      poff_in = 14'h1000;
      for (int i = 4; i < 8; i++) begin
         step();
         chk("poff_phase", 32'(phase), (i % 2 == 0) ? 4096 : 12288);
         chk("poff_wrap", 32'(wrap), 32'(i % 2 == 0));
      end

      // Pause at phase 500 and resume.
      do_reset();
      load_run(32'h0004_0000);
      for (int i = 0; i <= 500; i++) step();
      chk("pre_pause_phase", 32'(phase), 500);
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("pause_phase", 32'(phase), 500);
         chk("pause_valid", 32'(phase_valid), 0);
      end
      en = 1'b1;
      step();
      chk("resume_phase", 32'(phase), 501);
      chk("resume_valid", 32'(phase_valid), 1);
      step();
      chk("resume_phase2", 32'(phase), 502);

      // Word accepted at phase 100 waits for the wrap before the step doubles.
      do_reset();
      load_run(32'h0004_0000);
      for (int i = 0; i <= 100; i++) step();
      chk("aow_phase100", 32'(phase), 100);
      chk("aow_ready_before", 32'(ftw_ready), 1);
      apply_on_wrap = 1'b1;
      ftw_in = 32'h0008_0000;
      ftw_valid = 1'b1;
      for (int i = 101; i <= 16386; i++) begin
         step();
         ftw_valid = 1'b0;
         chk("aow_phase", 32'(phase), (i <= 16383) ? 32'(i) : 32'((i - 16384) * 2));
         chk("aow_wrap", 32'(wrap), 32'(i == 16384));
         if (i <= 16382) chk("aow_ready_pend", 32'(ftw_ready), 0);
         if (i >= 16384) chk("aow_ready_after", 32'(ftw_ready), 1);
      end

      // sync_clr together with a handshake applies the new word at once.
      do_reset();
      load_run(32'h0004_0000);
      for (int i = 0; i <= 9000; i++) step();
      chk("clr_phase9000", 32'(phase), 9000);
      apply_on_wrap = 1'b1;
      sync_clr = 1'b1;
      ftw_in = 32'h0008_0000;
      ftw_valid = 1'b1;
      step();
      sync_clr = 1'b0;
      ftw_valid = 1'b0;
      chk("clr_wrap0", 32'(wrap), 0);
      chk("clr_ready", 32'(ftw_ready), 1);
      step();
      chk("clr_phase0", 32'(phase), 0);
      chk("clr_wrap1", 32'(wrap), 0);
      step();
      chk("clr_newstep1", 32'(phase), 2);
      step();
      chk("clr_newstep2", 32'(phase), 4);

      // Reset while a word is pending: outputs clear asynchronously, word is lost.
      do_reset();
      load_run(32'h0004_0000);
      for (int i = 0; i <= 50; i++) step();
      apply_on_wrap = 1'b1;
      ftw_in = 32'h0008_0000;
      ftw_valid = 1'b1;
      step();
      ftw_valid = 1'b0;
      step();
      chk("pend_ready", 32'(ftw_ready), 0);
      chk("pend_phase", 32'(phase), 52);
      #2;
      rst = 1'b0;
      apply_on_wrap = 1'b0;
      #1;
      chk("arst_phase", 32'(phase), 0);
      chk("arst_valid", 32'(phase_valid), 0);
      chk("arst_wrap", 32'(wrap), 0);
      chk("arst_ready", 32'(ftw_ready), 1);
      step();
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("post_rst_phase", 32'(phase), 0);
         chk("post_rst_ready", 32'(ftw_ready), 1);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/dds_phase_accumulator.md
DDS_PHASE_ACCUMULATOR -- requirements
Module: dds_phase_accumulator

Interface
REQ-001 The block SHALL have parameter ACC_W, default 32, meaning accumulator width in bits.
REQ-002 The block SHALL have parameter PHASE_W, default 14, meaning output phase width, which addresses the waveform ROMs.
REQ-003 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  accumulate enable.
REQ-006 sync_clr  input  1  single-cycle pulse that clears the accumulator.
REQ-007 apply_on_wrap  input  1  selects when a new tuning word takes effect: 1 = at the next accumulator wrap, 0 = on the next cycle.
REQ-008 ftw_in  input  ACC_W  frequency tuning word.
REQ-009 ftw_valid  input  1  upstream has a tuning word on ftw_in.
REQ-010 ftw_ready  output  1  the block can accept a tuning word.
REQ-011 poff_in  input  PHASE_W  phase offset, sampled every cycle.
REQ-012 phase  output  PHASE_W  registered phase, equal to ROM address.
REQ-013 phase_valid  output  1  phase reflects an enabled accumulator.
REQ-014 wrap  output  1  single-cycle pulse, aligned with the phase sample that follows an accumulator overflow.

Function
REQ-015 Handshake: a word SHALL transfer when ftw_valid and ftw_ready are both high on a rising edge; ftw_in is then captured into the pending register.
REQ-016 The state machine SHALL have three states: IDLE (en=0), RUN (no pending word), PEND (a pending word waits for wrap).
REQ-017 ftw_ready SHALL be 1 in IDLE and RUN and 0 in PEND.
REQ-018 With apply_on_wrap=0, an accepted word SHALL move to the active register on the accepting edge and be used for the following cycle's add; the FSM SHALL stay in RUN (or IDLE).
REQ-019 With apply_on_wrap=1, an accepted word SHALL enter PEND; it SHALL become active on the same edge that the accumulator add overflows, or on sync_clr, whichever comes first; the FSM SHALL then return to RUN.
REQ-020 In RUN or PEND with en=1, each edge SHALL perform acc <= acc + ftw_active, modulo 2^ACC_W, with carry-out defining overflow.
REQ-021 With en=0, acc SHALL hold, phase_valid SHALL go 0 one cycle later, and handshakes SHALL still be accepted; from PEND, en=0 SHALL go to IDLE while keeping the pending word, which returns to PEND on en=1.
REQ-022 phase SHALL be registered as acc[ACC_W-1:ACC_W-PHASE_W] + poff_in, modulo 2^PHASE_W, giving 1-cycle latency from the acc register.
REQ-023 wrap SHALL be registered from the overflow carry so that it is aligned with the phase value computed from the post-overflow acc.
REQ-024 sync_clr SHALL set acc to 0 on that edge, irrespective of en; it SHALL win over the add and SHALL NOT assert wrap.
REQ-025 If sync_clr coincides with a handshake while apply_on_wrap=1, the new word SHALL become active immediately and the FSM SHALL go to RUN.
REQ-026 If a handshake coincides with an overflow in PEND, no transfer SHALL occur, since ftw_ready=0; the existing pending word SHALL apply.
REQ-027 A toggle of apply_on_wrap while in PEND SHALL NOT discard the pending word; a change to 0 SHALL apply the word on the next edge.

Reset
REQ-028 Asserting rst SHALL immediately clear the accumulator, the active and pending FTW, phase, phase_valid and wrap to 0, and set the FSM to IDLE.
REQ-029 ftw_ready SHALL be 1 during reset.
REQ-030 Reset mid-operation SHALL discard any pending word.
REQ-031 The first accumulation SHALL occur on the first edge after rst deasserts with en=1.

Structure
REQ-032 Shared package dds_pkg SHALL hold DDS_ACC_W, DDS_PHASE_W and the FSM state encoding (IDLE, RUN, PEND), for reuse by waveform ROMs and control logic.
REQ-033 Sub-module dds_ftw_buffer SHALL contain the handshake, pending register and FSM, and deliver ftw_active to the accumulator datapath in the top.

Verification
REQ-034 ftw=0x0004_0000, en=1, poff=0: phase SHALL be 0,1,2,… per cycle; 16383 SHALL be followed by 0 with wrap=1 for that one cycle; wrap period SHALL be 16384 cycles.
REQ-035 ftw=0x8000_0000: phase SHALL alternate 0, 8192, with wrap on every 0 sample; with poff=0x1000 it SHALL alternate 4096, 12288.
REQ-036 apply_on_wrap=1, running at 0x0004_0000, new word 0x0008_0000 accepted at phase 100: ftw_ready SHALL be 0 until wrap; the step SHALL become 2 only after wrap; ftw_ready SHALL be 1 the cycle after wrap.
REQ-037 en=0 for 10 cycles at phase 500: phase SHALL hold at 500 with phase_valid=0; on resume the next phase SHALL be 501.
REQ-038 sync_clr at phase 9000 together with a handshake, apply_on_wrap=1: phase SHALL become 0 with no wrap; the next phase SHALL use the new word.
REQ-039 rst asserted mid-PEND: all outputs SHALL be 0 and ftw_ready=1 asynchronously; the old word SHALL NOT apply after release.
